// File: rtl/cla_slice_sequencer.sv
// Feeds a wide add through an external W-bit adder one slice per step, LSB first,
// rippling the carry between slices and returning the reassembled sum on valid/ready.
module cla_slice_sequencer #(
  parameter int W        = 8,
  parameter int N_SLICES = 4,
  parameter int ADD_LAT  = 1
) (
  input  logic                  CLK_i,
  input  logic                  RST_N_I,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [W*N_SLICES-1:0] op_a_i,
  input  logic [W*N_SLICES-1:0] op_b_i,
  input  logic                  carry_in_i,
  output logic [W-1:0]          add_a_o,
  output logic [W-1:0]          add_b_o,
  output logic                  add_p_o,
  input  logic [W-1:0]          add_s_i,
  input  logic                  add_c_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [W*N_SLICES-1:0] sum_o,
  output logic                  carry_o,
  output logic                  busy_o
);

  localparam int WN = W * N_SLICES;
  localparam int KW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam int LW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [LW-1:0]   r_lat;
  // Operand registers hold only the slices not yet issued; they shift down by W per slice.
  logic [WN-1:0]   r_op_a;
  logic [WN-1:0]   r_op_b;
  logic [WN-1:0]   r_sum;
  logic            r_cout;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [W-1:0]    r_add_a;
  logic [W-1:0]    r_add_b;
  logic            r_add_p;

  logic [WN-1:0]   w_in_a_rest;
  logic [WN-1:0]   w_in_b_rest;
  logic [WN-1:0]   w_op_a_rest;
  logic [WN-1:0]   w_op_b_rest;
  logic            w_last_lat;
  logic            w_last_slice;

  assign w_in_a_rest  = op_a_i >> W;
  assign w_in_b_rest  = op_b_i >> W;
  assign w_op_a_rest  = r_op_a >> W;
  assign w_op_b_rest  = r_op_b >> W;
  assign w_last_lat   = (r_lat == LW'(ADD_LAT));
  assign w_last_slice = (r_k == KW'(N_SLICES - 1));

  always_ff @(posedge CLK_i) begin
    if (!RST_N_I) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_lat       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_p     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i && r_in_ready) begin
            r_state    <= ISSUE;
            r_k        <= '0;
            r_lat      <= '0;
            r_add_a    <= op_a_i[W-1:0];
            r_add_b    <= op_b_i[W-1:0];
            r_add_p    <= carry_in_i;
            r_op_a     <= w_in_a_rest;
            r_op_b     <= w_in_b_rest;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        ISSUE: begin
          if (w_last_lat) begin
            r_sum[r_k*W +: W] <= add_s_i;
            r_cout            <= add_c_i;
            r_lat             <= '0;
            if (w_last_slice) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_add_a     <= '0;
              r_add_b     <= '0;
              r_add_p     <= 1'b0;
            end else begin
              r_k     <= r_k + 1'b1;
              r_add_a <= r_op_a[W-1:0];
              r_add_b <= r_op_b[W-1:0];
              r_add_p <= add_c_i;
              r_op_a  <= w_op_a_rest;
              r_op_b  <= w_op_b_rest;
            end
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end

        DONE: begin
          // No bypass: in_ready only rises in the cycle after the result handshake.
          if (out_ready_i) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_add_a     <= '0;
          r_add_b     <= '0;
          r_add_p     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;
  assign add_a_o     = r_add_a;
  assign add_b_o     = r_add_b;
  assign add_p_o     = r_add_p;
  assign sum_o       = r_sum;
  assign carry_o     = r_cout;

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Bench for cla_slice_sequencer: directed literal cases on a default instance plus
// randomized traffic on several latency/width configurations against an arithmetic model.
module tb_cla_slice_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rdone [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- default instance (W=8, N_SLICES=4, ADD_LAT=1) ----------------
  logic        m_rst_n, m_iv, m_irdy, m_cin, m_addp, m_addc, m_ov, m_ordy, m_cout, m_busy;
  logic [31:0] m_a, m_b, m_sum;
  logic [7:0]  m_adda, m_addb, m_adds;
  logic [16:0] m_pipe;

  cla_slice_sequencer #(.W(8), .N_SLICES(4), .ADD_LAT(1)) u_dut (
    .CLK_i(clk), .RST_N_I(m_rst_n), .in_valid_i(m_iv), .in_ready_o(m_irdy),
    .op_a_i(m_a), .op_b_i(m_b), .carry_in_i(m_cin),
    .add_a_o(m_adda), .add_b_o(m_addb), .add_p_o(m_addp),
    .add_s_i(m_adds), .add_c_i(m_addc),
    .out_valid_o(m_ov), .out_ready_i(m_ordy),
    .sum_o(m_sum), .carry_o(m_cout), .busy_o(m_busy)
  );

  // One-cycle adder: result reflects the slice driven in the previous cycle.
  always_ff @(posedge clk) m_pipe <= {m_addp, m_adda, m_addb};
  assign {m_addc, m_adds} = {1'b0, m_pipe[15:8]} + {1'b0, m_pipe[7:0]} + {8'd0, m_pipe[16]};

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input int hold, input logic [31:0] exp_sum, input logic exp_c,
                       input logic exp_p1, input logic [7:0] exp_a0);
    int k;
    bit seen;
    @(posedge clk); #1;
    m_a = a; m_b = b; m_cin = cin; m_iv = 1'b1; m_ordy = (hold == 0);
    k = 0;
    @(negedge clk);
    while (!m_irdy && k < 50) begin @(negedge clk); k++; end
    chk("op_accept_ready", m_irdy, 1'b1);
    @(posedge clk); #1;
    m_iv = 1'b0;
    k = 0; seen = 0;
    while (!seen && k <= 40) begin
      @(negedge clk);
      if (k == 0) chk("slice0_add_a", m_adda, exp_a0);
      if (k == 2) chk("slice1_add_p", m_addp, exp_p1);
      if (m_ov) seen = 1; else k++;
    end
    chk("op_latency", k, 8);
    chk("op_sum", m_sum, exp_sum);
    chk("op_carry", m_cout, exp_c);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      m_iv = ~m_iv; m_a = $urandom; m_b = $urandom; m_cin = ~m_cin;
      @(negedge clk);
      chk("bp_sum_stable", m_sum, exp_sum);
      chk("bp_carry_stable", m_cout, exp_c);
      chk("bp_in_ready_low", m_irdy, 1'b0);
      chk("bp_valid_held", m_ov, 1'b1);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      m_iv = 1'b0; m_ordy = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_valid_low", m_ov, 1'b0);
    chk("post_hs_in_ready", m_irdy, 1'b1);
  endtask

  initial begin
    int t;
    bit bad;
    m_rst_n = 1'b0; m_iv = 1'b1; m_a = 32'hA5A5_5A5A; m_b = 32'h1234_5678;
    m_cin = 1'b1; m_ordy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", m_irdy, 1'b1);
    chk("rst_out_valid", m_ov, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_add_a", m_adda, 8'h00);
    chk("rst_add_b", m_addb, 8'h00);
    chk("rst_add_p", m_addp, 1'b0);
    chk("rst_sum", m_sum, 32'h0);
    chk("rst_carry", m_cout, 1'b0);
    @(posedge clk); #1;
    m_rst_n = 1'b1; m_iv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", m_irdy, 1'b1);
    chk("release_busy", m_busy, 1'b0);

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 32'h0000_0100, 1'b0, 1'b1, 8'hFF);
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 32'h0000_0000, 1'b1, 1'b1, 8'hFF);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b0, 8'h00);
    do_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 5, 32'hDFD1_0457, 1'b0, 1'b1, 8'hEF);

    // Abort while slice 2 is on the adder.
    @(posedge clk); #1;
    m_a = 32'hCAFE_F00D; m_b = 32'h0BAD_BEEF; m_cin = 1'b0; m_iv = 1'b1;
    @(negedge clk);
    chk("abort_accept_ready", m_irdy, 1'b1);
    @(posedge clk); #1;
    m_iv = 1'b0;
    repeat (4) @(posedge clk);
    #1 m_rst_n = 1'b0;
    @(posedge clk); #1;
    m_rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", m_irdy, 1'b1);
    chk("abort_busy", m_busy, 1'b0);
    chk("abort_sum_cleared", m_sum, 32'h0);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_ov) bad = 1;
    end
    chk("abort_no_valid", bad, 1'b0);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0, 32'h2345_6789, 1'b0, 1'b0, 8'h78);

    t = 0;
    while (!(rdone[0] && rdone[1] && rdone[2] && rdone[3]) && t < 40000) begin
      @(posedge clk); t++;
    end
    chk("rnd_all_complete", rdone[0] && rdone[1] && rdone[2] && rdone[3], 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- randomized instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int LAT = (g == 0) ? 0 : ((g == 2) ? 3 : 1);
    localparam int NS  = (g == 3) ? 1 : 4;
    localparam int WW  = 8 * NS;
    localparam int PL  = (LAT > 0) ? LAT : 1;

    logic          rst_n, iv, irdy, cin, addp, addc, ov, ordy, cout, busy;
    logic [WW-1:0] a, b, sum;
    logic [7:0]    adda, addb, adds;
    logic [16:0]   pipe [PL];
    logic [16:0]   tap;
    logic [WW:0]   expq [$];
    int            accq [$];
    bit            pv = 1'b0;

    cla_slice_sequencer #(.W(8), .N_SLICES(NS), .ADD_LAT(LAT)) u_dut (
      .CLK_i(clk), .RST_N_I(rst_n), .in_valid_i(iv), .in_ready_o(irdy),
      .op_a_i(a), .op_b_i(b), .carry_in_i(cin),
      .add_a_o(adda), .add_b_o(addb), .add_p_o(addp),
      .add_s_i(adds), .add_c_i(addc),
      .out_valid_o(ov), .out_ready_i(ordy),
      .sum_o(sum), .carry_o(cout), .busy_o(busy)
    );

    // Adder whose result is only valid LAT cycles after its inputs settle.
    always_ff @(posedge clk) begin
      pipe[0] <= {addp, adda, addb};
      for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
    end
    assign tap = (LAT == 0) ? {addp, adda, addb} : pipe[PL-1];
    assign {addc, adds} = {1'b0, tap[15:8]} + {1'b0, tap[7:0]} + {8'd0, tap[16]};

    initial begin
      int t;
      rst_n = 1'b0; iv = 1'b0; cin = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int n = 0; n < 250; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        a = WW'(rnd_op()); b = WW'(rnd_op()); cin = 1'($urandom_range(0, 1)); iv = 1'b1;
        t = 0;
        @(negedge clk);
        while (!irdy && t < 100) begin @(negedge clk); t++; end
        chk($sformatf("rnd%0d_accept_wait", g), irdy, 1'b1);
        @(posedge clk); #1;
        iv = 1'b0;
      end
      t = 0;
      while (expq.size() != 0 && t < 200) begin @(posedge clk); t++; end
      chk($sformatf("rnd%0d_drain", g), expq.size(), 0);
      rdone[g] = 1'b1;
    end

    initial forever begin
      @(posedge clk); #1;
      ordy = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        if (ov) begin
          if (expq.size() == 0) begin
            chk($sformatf("rnd%0d_spurious_valid", g), ov, 1'b0);
          end else begin
            if (!pv) chk($sformatf("rnd%0d_latency", g), cyc - accq[0], NS * (LAT + 1));
            chk($sformatf("rnd%0d_result", g), {cout, sum}, expq[0]);
            if (ordy) begin
              void'(expq.pop_front());
              void'(accq.pop_front());
            end
          end
        end
        if (irdy) chk($sformatf("rnd%0d_single_in_flight", g), expq.size(), 0);
        if (iv && irdy) begin
          expq.push_back({1'b0, a} + {1'b0, b} + {{WW{1'b0}}, cin});
          accq.push_back(cyc + 1);
        end
        pv = ov;
      end
    end
  end

endmodule
